a51: RTL and testbench

//  A5/1 (GSM) keystream generator: three majority-clocked LFSRs (19/22/23 bit), self-loading
//  a fixed 64-bit key and 22-bit frame number after reset, then emitting 228 keystream bits.

---
 rtl/a51_pkg.sv | 36 +++
 rtl/a51_lfsr.sv | 30 +++
 rtl/a51.sv | 92 +++++++++
 tb/tb_a51.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/a51_pkg.sv
// Shared constants and types for the A5/1 keystream generator:
// register geometry, feedback taps, clocking bits and phase lengths.
package a51_pkg;

    localparam int R1_W = 19;
    localparam int R2_W = 22;
    localparam int R3_W = 23;

    // Tap masks: R1 {18,17,16,13}, R2 {21,20}, R3 {22,21,20,7}
    localparam logic [R1_W-1:0] R1_TAPS = 19'h72000;
    localparam logic [R2_W-1:0] R2_TAPS = 22'h300000;
    localparam logic [R3_W-1:0] R3_TAPS = 23'h700080;

    localparam int R1_CLK = 8;
    localparam int R2_CLK = 10;
    localparam int R3_CLK = 10;

    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0] KEY_LAST   = 9'd63;
    localparam logic [CNT_W-1:0] FRAME_LAST = 9'd21;
    localparam logic [CNT_W-1:0] MIX_LAST   = 9'd99;
    localparam logic [CNT_W-1:0] KS_LAST    = 9'd227;

    typedef enum logic [2:0] {
        LOAD_KEY,
        LOAD_FRAME,
        MIX,
        KEYSTREAM,
        DONE
    } phase_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/a51_lfsr.sv
// Fibonacci LFSR that shifts left when enabled; the new LSB is the XOR of
// the tapped bits with an externally injected key/frame bit.
module a51_lfsr #(
    parameter int           W    = 19,
    parameter logic [W-1:0] TAPS = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         inj_i,
    output logic [W-1:0] state_o
);

    logic [W-1:0] state_q;
    logic         fb;

    assign fb      = (^(state_q & TAPS)) ^ inj_i;
    assign state_o = state_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design samples pre-edge values of its neighbours.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= '0;
        end else if (en_i) begin
            state_q <= {state_q[W-2:0], fb};
        end
    end

endmodule

// File: rtl/a51.sv
// A5/1 core: loads KEY then FRAME into three LFSRs, mixes for 100 cycles,
// emits 228 keystream bits, then freezes until the next reset.
module a51
    import a51_pkg::*;
#(
    parameter logic [63:0] KEY   = 64'h0,
    parameter logic [21:0] FRAME = 22'h0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        out,
    output logic [18:0] out19,
    output logic [21:0] out22,
    output logic [22:0] out23,
    output logic [85:0] testout
);

    phase_e            phase_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        en;
    logic              inj;
    logic              maj;
    logic [31:0]       frame_pad;

    assign frame_pad = {10'b0, FRAME};
    assign maj       = maj3(out19[R1_CLK], out22[R2_CLK], out23[R3_CLK]);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase_q <= LOAD_KEY;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            unique case (phase_q)
                LOAD_KEY: if (cnt_q == KEY_LAST) begin
                    phase_q <= LOAD_FRAME;
                    cnt_q   <= '0;
                end
                LOAD_FRAME: if (cnt_q == FRAME_LAST) begin
                    phase_q <= MIX;
                    cnt_q   <= '0;
                end
                MIX: if (cnt_q == MIX_LAST) begin
                    phase_q <= KEYSTREAM;
                    cnt_q   <= '0;
                end
                KEYSTREAM: if (cnt_q == KS_LAST) begin
                    phase_q <= DONE;
                    cnt_q   <= '0;
                end
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Load phases clock all registers; mixing phases clock only the majority.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        en  = 3'b000;
        inj = 1'b0;
        unique case (phase_q)
            LOAD_KEY: begin
                en  = 3'b111;
                inj = KEY[cnt_q[5:0]];
            end
            LOAD_FRAME: begin
                en  = 3'b111;
                inj = frame_pad[cnt_q[4:0]];
            end
            MIX, KEYSTREAM: begin
                en[0] = (out19[R1_CLK] == maj);
                en[1] = (out22[R2_CLK] == maj);
                en[2] = (out23[R3_CLK] == maj);
            end
            default: ;
        endcase
    end

    a51_lfsr #(.W(R1_W), .TAPS(R1_TAPS)) u_r1 (
        .clk_i(clock), .rst_ni(reset), .en_i(en[0]), .inj_i(inj), .state_o(out19)
    );
    a51_lfsr #(.W(R2_W), .TAPS(R2_TAPS)) u_r2 (
        .clk_i(clock), .rst_ni(reset), .en_i(en[1]), .inj_i(inj), .state_o(out22)
    );
    a51_lfsr #(.W(R3_W), .TAPS(R3_TAPS)) u_r3 (
        .clk_i(clock), .rst_ni(reset), .en_i(en[2]), .inj_i(inj), .state_o(out23)
    );

    assign out     = (phase_q == KEYSTREAM) & (out19[18] ^ out22[21] ^ out23[22]);
    assign testout = {FRAME, KEY};

endmodule

// File: tb/tb_a51.sv
// Directed bench for a51: three instances (zero key, single-bit key, full key)
// checked against hand values and an independent bit-level A5/1 model.
module tb_a51;

    localparam logic [63:0] KEY_C   = 64'h1223456789ABCDEF;
    localparam logic [21:0] FRAME_C = 22'h134;

    logic        clk;
    logic        rst_n;

    logic        a_out, b_out, c_out;
    logic [18:0] a_r1, b_r1, c_r1;
    logic [21:0] a_r2, b_r2, c_r2;
    logic [22:0] a_r3, b_r3, c_r3;
    logic [85:0] a_t, b_t, c_t;

    int tests = 0;
    int fails = 0;

    logic [18:0] m1;
    logic [21:0] m2;
    logic [22:0] m3;
    logic        ks [0:227];

    logic [18:0] b_r1_snap;
    logic [21:0] b_r2_snap;
    logic [22:0] b_r3_snap;

    a51 #(.KEY(64'h0), .FRAME(22'h0)) u_a (
        .clock(clk), .reset(rst_n), .out(a_out),
        .out19(a_r1), .out22(a_r2), .out23(a_r3), .testout(a_t)
    );
    a51 #(.KEY(64'h1), .FRAME(22'h0)) u_b (
        .clock(clk), .reset(rst_n), .out(b_out),
        .out19(b_r1), .out22(b_r2), .out23(b_r3), .testout(b_t)
    );
    a51 #(.KEY(KEY_C), .FRAME(FRAME_C)) u_c (
        .clock(clk), .reset(rst_n), .out(c_out),
        .out19(c_r1), .out22(c_r2), .out23(c_r3), .testout(c_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [85:0] obs, input logic [85:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance the reference model from cycle k to cycle k+1.
    task automatic model_step(input int k);
        logic inj, m, e1, e2, e3;
        inj = 1'b0;
        e1 = 1'b0; e2 = 1'b0; e3 = 1'b0;
        if (k < 64) begin
            inj = KEY_C[k];
            e1 = 1'b1; e2 = 1'b1; e3 = 1'b1;
        end else if (k < 86) begin
            inj = FRAME_C[k-64];
            e1 = 1'b1; e2 = 1'b1; e3 = 1'b1;
        end else if (k < 414) begin
            m  = (int'(m1[8]) + int'(m2[10]) + int'(m3[10])) >= 2;
            e1 = (m1[8] == m);
            e2 = (m2[10] == m);
            e3 = (m3[10] == m);
        end
        if (e1) m1 = {m1[17:0], m1[18] ^ m1[17] ^ m1[16] ^ m1[13] ^ inj};
        if (e2) m2 = {m2[20:0], m2[21] ^ m2[20] ^ inj};
        if (e3) m3 = {m3[21:0], m3[22] ^ m3[21] ^ m3[20] ^ m3[7] ^ inj};
    endtask

    function automatic logic model_out(input int k);
        return (k >= 186 && k <= 413) ? (m1[18] ^ m2[21] ^ m3[22]) : 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        m1 = '0; m2 = '0; m3 = '0;

        // Reset held across several edges: everything stays cleared.
        repeat (3) tick();
        check("rst_a_state", 86'({a_r1, a_r2, a_r3, a_out}), 86'd0);
        check("rst_b_state", 86'({b_r1, b_r2, b_r3, b_out}), 86'd0);
        check("rst_c_state", 86'({c_r1, c_r2, c_r3, c_out}), 86'd0);
        check("testout_a", a_t, 86'd0);
        check("testout_b", b_t, {22'h0, 64'h1});
        check("testout_c", c_t, {FRAME_C, KEY_C});

        // First full run.
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 450; k++) begin
            check("a_all_zero", 86'({a_r1, a_r2, a_r3, a_out}), 86'd0);
            check("c_regs", 86'({c_r1, c_r2, c_r3}), 86'({m1, m2, m3}));
            check("c_out", 86'(c_out), 86'(model_out(k)));
            if (k >= 186 && k <= 413) ks[k-186] = model_out(k);
            if (k < 186 || k >= 414) check("b_out_idle", 86'(b_out), 86'd0);
            if (k == 1) begin
                check("b_cyc1", 86'({b_r1, b_r2, b_r3}), 86'({19'd1, 22'd1, 23'd1}));
                check("c_cyc1", 86'({c_r1, c_r2, c_r3}), 86'({19'd1, 22'd1, 23'd1}));
            end
            if (k == 2) begin
                check("b_cyc2", 86'({b_r1, b_r2, b_r3}), 86'({19'd2, 22'd2, 23'd2}));
                check("c_cyc2", 86'({c_r1, c_r2, c_r3}), 86'({19'd3, 22'd3, 23'd3}));
            end
            if (k == 414) begin
                b_r1_snap = b_r1;
                b_r2_snap = b_r2;
                b_r3_snap = b_r3;
            end
            if (k == 449)
                check("b_frozen", 86'({b_r1, b_r2, b_r3}), 86'({b_r1_snap, b_r2_snap, b_r3_snap}));
            tick();
            model_step(k);
        end
        check("testout_c_end", c_t, {FRAME_C, KEY_C});

        // Second run, interrupted by reset in cycle 200 (KEYSTREAM).
        rst_n = 1'b0;
        m1 = '0; m2 = '0; m3 = '0;
        #1;
        check("c_clear_end", 86'({c_r1, c_r2, c_r3, c_out}), 86'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= 200; k++) begin
            check("c2_regs", 86'({c_r1, c_r2, c_r3}), 86'({m1, m2, m3}));
            check("c2_out", 86'(c_out), 86'(model_out(k)));
            if (k < 200) begin
                tick();
                model_step(k);
            end
        end
        rst_n = 1'b0;
        #1;
        check("c_async_clear", 86'({c_r1, c_r2, c_r3, c_out}), 86'd0);
        check("b_async_clear", 86'({b_r1, b_r2, b_r3, b_out}), 86'd0);
        repeat (2) tick();
        check("c_reset_hold", 86'({c_r1, c_r2, c_r3, c_out}), 86'd0);

        // Third run: keystream must repeat the first run bit for bit.
        m1 = '0; m2 = '0; m3 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k <= 414; k++) begin
            if (k >= 186 && k <= 413) check("c3_ks_repeat", 86'(c_out), 86'(ks[k-186]));
            else check("c3_out_idle", 86'(c_out), 86'd0);
            check("c3_regs", 86'({c_r1, c_r2, c_r3}), 86'({m1, m2, m3}));
            tick();
            model_step(k);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
